generic_io_dft_in: RTL
======================

// Module: generic_io_dft_in
// PURPOSE
//  Input-side IO DFT checker: receive-side partner of the IO DFT output LFSR generator. Sits on the pad input
//  register path and checks a parallel LFSR pattern arriving on func_datap_in. Self-synchronises a local LFSR to
//  the received stream, then counts bit-word errors per cycle. Status goes to BootCFG; control comes from BootCFG
//  or the ATE pins.
// PARAMETERS
//  IO_DFT_IN_DW   8      data width, 2..32
//  LFSR_TAPS      8'hB8  feedback tap mask [IO_DFT_IN_DW-1:0]; nxt(x) = {x[DW-2:0], ^(x & LFSR_TAPS)}
//  LOCK_CNT       4      consecutive matches to declare lock, 1..255
//  ERR_CW         16     error counter width, 2..32
//  MISR_SEED      0      MISR reload value [IO_DFT_IN_DW-1:0] (macro build only)
// PORTS
//  func_clk                 in   1      functional clock
//  func_rst                 in   1      synchronous reset, active high
//  bcfg_io_dft_in_ate_en    in   1      1: control from ATE pin; 0: from BootCFG (static)
//  bcfg_io_dft_in_en        in   1      BootCFG enable, async to func_clk; crg_sync2 inside
//  io_dft_in_en             in   1      ATE enable, synchronous to func_clk
//  func_datap_in            in   DW     received word from IO input register
//  bcfg_io_dft_in_active    out  1      FSM not in IDLE
//  bcfg_io_dft_in_locked    out  1      FSM in LOCK
//  bcfg_io_dft_in_err       out  1      sticky: >=1 error since last ACQ entry
//  bcfg_io_dft_in_err_cnt   out  ERR_CW mismatching words since last ACQ entry, saturating
//  bcfg_io_dft_in_misr      out  DW     signature of received words (macro build only)
// BEHAVIOUR
//  - en_i = ate_en ? io_dft_in_en : sync2(bcfg_io_dft_in_en). All outputs reset to 0; misr resets to MISR_SEED.
//  - FSM IDLE/ACQ/LOCK. IDLE->ACQ when en_i=1. ACQ->LOCK on LOCK_CNT-th consecutive match. Any state->IDLE when en_i=0.
//  - On IDLE->ACQ: clear err_cnt, err and match_cnt; prev_vld<=0.
//  - ACQ, each cycle:
//      prev <= data; prev_vld <= 1.
//      match = prev_vld && data == nxt(prev) && data != 0.
//      match: match_cnt++.
//      Mismatch: match_cnt <= 0; no error counted.
//      All-zero word never matches (prevents lock on stuck-0 pads).
//  - Lock: on the cycle that samples the LOCK_CNT-th consecutive match: local <= data, state <= LOCK.
//    locked=1 from the next cycle.
//  - LOCK, each cycle:
//      Expected word = nxt(local).
//      If data != expected: err_cnt <= sat(err_cnt+1), err <= 1.
//      local <= expected regardless of match, so the local LFSR free-runs and never resyncs in LOCK.
//  - err_cnt saturates at all-ones and holds.
//  - Latency: word sampled at edge n -> err_cnt/err updated at edge n+1.
//  - IDLE holds err_cnt/err for BootCFG readout; locked=0, active=0 in IDLE.
//  - en_i falling in LOCK: the word sampled that same cycle is not checked.
//  - Reset mid-operation: IDLE and all outputs 0 at the next edge.
//  - Simultaneous reset and en_i=1: reset wins.
// CONFIGURATION
//  - IO_DFT_IN_MISR_EN defined: misr <= nxt(misr) ^ data every cycle in ACQ and LOCK; misr <= MISR_SEED on IDLE->ACQ;
//    held in IDLE.
//  - Not defined: bcfg_io_dft_in_misr tied to {DW{1'b0}}; no MISR flops.
// TESTING  (DW=8, TAPS=8'hB8, LOCK_CNT=4, ATE mode unless noted)
//  - en=1; drive LFSR sequence from 8'h01 one word/clk -> locked=1 the cycle after the 5th word; err_cnt=0 after 100 words.
//  - After lock, invert bit0 of one word -> err_cnt=1, err=1 one cycle later; locked stays 1; following words count 0.
//  - ACQ: 3 good words, 1 corrupted, then good -> lock needs 4 further consecutive matches (no early lock).
//  - Constant 8'h00 input for 50 clks -> locked stays 0, err_cnt=0.
//  - ERR_CW=4: lock, then 20 corrupt words -> err_cnt=4'hF; en=0 -> err_cnt holds 4'hF; en=1 -> clears to 0.
//  - BootCFG mode (ate_en=0): en pulse -> active rises 2-3 clks later; func_rst=1 mid-LOCK -> all outputs 0 next edge.
//    With IO_DFT_IN_MISR_EN defined, misr matches the reference model after 64 words.

Source files
------------

// File: rtl/generic_io_dft_in_if.sv
// Pad-side IO DFT checker bus: control/data in from BootCFG/ATE/pads, status out to BootCFG.
interface generic_io_dft_in_if #(
  parameter int unsigned DW     = 8,
  parameter int unsigned ERR_CW = 16
) ();
  logic              bcfg_io_dft_in_ate_en;
  logic              bcfg_io_dft_in_en;
  logic              io_dft_in_en;
  logic [DW-1:0]     func_datap_in;
  logic              bcfg_io_dft_in_active;
  logic              bcfg_io_dft_in_locked;
  logic              bcfg_io_dft_in_err;
  logic [ERR_CW-1:0] bcfg_io_dft_in_err_cnt;
  logic [DW-1:0]     bcfg_io_dft_in_misr;

  modport slave (
    input  bcfg_io_dft_in_ate_en, bcfg_io_dft_in_en, io_dft_in_en, func_datap_in,
    output bcfg_io_dft_in_active, bcfg_io_dft_in_locked, bcfg_io_dft_in_err,
           bcfg_io_dft_in_err_cnt, bcfg_io_dft_in_misr
  );

  modport master (
    output bcfg_io_dft_in_ate_en, bcfg_io_dft_in_en, io_dft_in_en, func_datap_in,
    input  bcfg_io_dft_in_active, bcfg_io_dft_in_locked, bcfg_io_dft_in_err,
           bcfg_io_dft_in_err_cnt, bcfg_io_dft_in_misr
  );
endinterface

// File: rtl/generic_io_dft_in.sv
// Receive-side IO DFT LFSR checker: self-syncs a local LFSR to the pad stream, then counts word errors.
// Optional received-word signature register enabled by defining IO_DFT_IN_MISR_EN.
module generic_io_dft_in #(
  parameter int unsigned             IO_DFT_IN_DW = 8,
  parameter logic [IO_DFT_IN_DW-1:0] LFSR_TAPS    = IO_DFT_IN_DW'(8'hB8),
  parameter int unsigned             LOCK_CNT     = 4,
  parameter int unsigned             ERR_CW       = 16
`ifdef IO_DFT_IN_MISR_EN
  , parameter logic [IO_DFT_IN_DW-1:0] MISR_SEED  = '0
`endif
) (
  input  logic               func_clk,
  input  logic               func_rst,
  generic_io_dft_in_if.slave dft_if
);

  localparam int unsigned DW    = IO_DFT_IN_DW;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {ST_IDLE, ST_ACQ, ST_LOCK} state_e;

  function automatic logic [DW-1:0] lfsr_nxt(input logic [DW-1:0] x);
    return {x[DW-2:0], ^(x & LFSR_TAPS)};
  endfunction

  state_e            state_q, state_d;
  logic [1:0]        sync_q, sync_d;
  logic [DW-1:0]     prev_q, prev_d;
  logic              prev_vld_q, prev_vld_d;
  logic [CNT_W-1:0]  match_cnt_q, match_cnt_d;
  logic [DW-1:0]     local_q, local_d;
  logic              err_q, err_d;
  logic [ERR_CW-1:0] err_cnt_q, err_cnt_d;
  logic              active_q, active_d;
  logic              locked_q, locked_d;

  logic              en_c;
  logic              match_c;
  logic [DW-1:0]     expect_c;
  logic [DW-1:0]     data_c;

  assign data_c = dft_if.func_datap_in;
  assign en_c   = dft_if.bcfg_io_dft_in_ate_en ? dft_if.io_dft_in_en : sync_q[1];

  always_ff @(posedge func_clk) begin
    if (func_rst) begin
      state_q     <= ST_IDLE;
      sync_q      <= '0;
      prev_q      <= '0;
      prev_vld_q  <= 1'b0;
      match_cnt_q <= '0;
      local_q     <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      active_q    <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      prev_q      <= prev_d;
      prev_vld_q  <= prev_vld_d;
      match_cnt_q <= match_cnt_d;
      local_q     <= local_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      active_q    <= active_d;
      locked_q    <= locked_d;
    end
  end

  // Next state: acquire on LOCK_CNT consecutive nonzero LFSR steps, then free-run and count errors.
  always_comb begin
    state_d     = state_q;
    sync_d      = {sync_q[0], dft_if.bcfg_io_dft_in_en};
    prev_d      = prev_q;
    prev_vld_d  = prev_vld_q;
    match_cnt_d = match_cnt_q;
    local_d     = local_q;
    err_d       = err_q;
    err_cnt_d   = err_cnt_q;
    expect_c    = lfsr_nxt(local_q);
    match_c     = prev_vld_q && (data_c == lfsr_nxt(prev_q)) && (data_c != '0);

    if (!en_c) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d     = ST_ACQ;
          err_d       = 1'b0;
          err_cnt_d   = '0;
          match_cnt_d = '0;
          prev_vld_d  = 1'b0;
        end
        ST_ACQ: begin
          prev_d     = data_c;
          prev_vld_d = 1'b1;
          if (!match_c) begin
            match_cnt_d = '0;
          end else if (match_cnt_q == CNT_W'(LOCK_CNT - 1)) begin
            state_d     = ST_LOCK;
            local_d     = data_c;
            match_cnt_d = '0;
          end else begin
            match_cnt_d = match_cnt_q + CNT_W'(1);
          end
        end
        ST_LOCK: begin
          local_d = expect_c;
          if (data_c != expect_c) begin
            err_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    active_d = (state_d != ST_IDLE);
    locked_d = (state_d == ST_LOCK);
  end

  assign dft_if.bcfg_io_dft_in_active  = active_q;
  assign dft_if.bcfg_io_dft_in_locked  = locked_q;
  assign dft_if.bcfg_io_dft_in_err     = err_q;
  assign dft_if.bcfg_io_dft_in_err_cnt = err_cnt_q;

`ifdef IO_DFT_IN_MISR_EN
  logic [DW-1:0] misr_q, misr_d;

  // Signature of every word received while enabled; reseeded on each acquisition start.
  always_comb begin
    misr_d = misr_q;
    if (en_c) begin
      if (state_q == ST_IDLE) misr_d = MISR_SEED;
      else                    misr_d = lfsr_nxt(misr_q) ^ data_c;
    end
  end

  always_ff @(posedge func_clk) begin
    if (func_rst) misr_q <= MISR_SEED;
    else          misr_q <= misr_d;
  end

  assign dft_if.bcfg_io_dft_in_misr = misr_q;
`else
  assign dft_if.bcfg_io_dft_in_misr = {DW{1'b0}};
`endif

endmodule
